uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Transmit-side byte queue placed directly upstream of the UART transmitter. Bus-side logic writes bytes into a power-of-two FIFO. The block pops one byte at a time and launches it on the transmitter with a single-cycle `tx_start`. It then waits for the transmitter's `tx_end` before launching the next byte, so back-to-back bytes go out without CPU polling per character.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, min 2.
- `ADDR_W`, 4: log2(DEPTH).
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset. One clock domain; polarity and synchronicity are fixed.
- `wr_en`  in  1  push `wr_data` this cycle.
- `wr_data`  in  8  byte to queue.
- `flush`  in  1  discard all queued bytes.
- `tx_en`  in  1  launch permission; 0 holds the queue without losing data.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  ADDR_W+1  bytes queued, 0..DEPTH.
- `overflow`  out  1  one-cycle pulse when a write is dropped.
- `tx_start`  out  1  one-cycle launch strobe to the transmitter.
- `tx_data`  out  8  byte being launched; held stable until the next launch.
- `tx_busy`  in  1  transmitter frame in progress.
- `tx_end`  in  1  transmitter one-cycle frame-done pulse.

## Operation
- Storage: DEPTH×8 register array; `rd_ptr`/`wr_ptr` ADDR_W bits wrap modulo DEPTH; `count` ADDR_W+1 bits; `full`/`empty` registered, derived from next count.
- Push: `wr_en && !full && !flush` writes `mem[wr_ptr]`, `wr_ptr`+1.
- Push while full drops the byte and pulses `overflow` for 1 cycle. This applies even if a pop occurs the same cycle, because the full check uses the current-cycle `full`.
- Pop: occurs only on launch (below); `rd_ptr`+1.
- Push+pop same cycle: count unchanged.
- Flush: pointers and count go to 0, `empty`=1, `full`=0. Flush wins over a same-cycle push (no overflow pulse) and a same-cycle pop (no launch). Flush does not abort a frame already launched; the FSM still waits for `tx_end`.
- FSM, 2 states:
  - IDLE: if `!empty && tx_en && !tx_busy && !flush`, then `tx_start`<=1, `tx_data`<=`mem[rd_ptr]`, pop, go to WAIT.
  - WAIT: `tx_start`<=0. On `tx_end`=1, go to IDLE. Otherwise stay; `tx_busy` is ignored here.
- `tx_en` dropping in WAIT does not stop the current frame; it only blocks the next launch.

## Timing
- Reset values: state IDLE, `tx_start` 0, `tx_data` 8'h00, `count` 0, `empty` 1, `full` 0, `overflow` 0, pointers 0. Memory contents are not reset.
- Write sampled at edge N: `count`/`empty` update after edge N. First `tx_start` is high after edge N+1, with `tx_data` valid in the same cycle.
- `tx_start` is exactly one cycle wide; the transmitter samples `tx_data` in that cycle.
- `tx_end` sampled at edge M: FSM is in IDLE after M. The next `tx_start` is high after M+1 if data is available.
- Inter-frame gap: transmitter frame time plus 2 cycles.
- `overflow` is high the cycle after the dropped write's edge, for one cycle.
- Reset mid-frame: the FIFO empties and the FSM returns to IDLE. The transmitter shares the reset.

## Test plan
- Reset, then write 8'hA5 once: after 1 edge `count`=1, `empty`=0. Next cycle `tx_start`=1, `tx_data`=8'hA5, `count`=0. No second `tx_start` until `tx_end` is pulsed.
- Write 8'h01,8'h02,8'h03 back-to-back while `tx_busy` is held 1: no launch. Release `tx_busy` with `tx_end` pulses: launches in order 01, 02, 03, each exactly 2 cycles after the preceding `tx_end`.
- With `tx_en`=0, write DEPTH=16 bytes 0x00..0x0F: `full`=1, `count`=16. Write a 17th byte 0xFF: `overflow` pulses once, `count` stays 16. Set `tx_en`=1: 0x00..0x0F are transmitted, with no 0xFF.
- `full`, then assert `wr_en` and launch in the same cycle: write dropped, `overflow`=1, `count`=15.
- Queue 4 bytes, launch the first, then assert `flush` together with `wr_en`: `count`=0, no overflow. FSM stays in WAIT until `tx_end`, then idles with no further `tx_start`.
- Assert `reset` while in WAIT with 5 queued: the next cycle shows all reset values, and no `tx_start` occurs afterwards without new writes.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Transmit byte queue feeding a UART transmitter.
// Bytes are pushed from the bus side into a power-of-two FIFO. One byte at a
// time is popped and launched with a single-cycle tx_start. The next byte is
// not launched until the transmitter reports tx_end.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              flush,
  input  logic              tx_en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  input  logic              tx_end
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [7:0]        mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              full_r;
  logic              empty_r;
  logic              overflow_r;
  logic              tx_start_r;
  logic [7:0]        tx_data_r;
  state_t            state_r;

  logic              push_s;
  logic              drop_s;
  logic              launch_s;
  logic [ADDR_W:0]   count_nxt_s;
  state_t            state_nxt_s;
  logic              tx_start_nxt_s;
  logic [7:0]        tx_data_nxt_s;

  // The full check uses the registered flag, so a write into a full queue is
  // dropped even when a launch frees a slot in the same cycle.
  assign push_s   = wr_en && !full_r && !flush;
  assign drop_s   = wr_en &&  full_r && !flush;
  // Flush suppresses a launch; tx_busy only matters while idle.
  assign launch_s = (state_r == ST_IDLE) && !empty_r && tx_en && !tx_busy && !flush;

  // Next occupancy: flush clears, push and pop in the same cycle cancel.
  always_comb begin
    count_nxt_s = count_r;
    if (flush) begin
      count_nxt_s = CNT_ZERO;
    end else if (push_s && !launch_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (!push_s && launch_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Launch FSM: next state and next values of the registered launch outputs.
  always_comb begin
    state_nxt_s    = state_r;
    tx_start_nxt_s = 1'b0;
    tx_data_nxt_s  = tx_data_r;
    case (state_r)
      ST_IDLE: begin
        if (launch_s) begin
          tx_start_nxt_s = 1'b1;
          tx_data_nxt_s  = mem_r[rd_ptr_r];
          state_nxt_s    = ST_WAIT;
        end else begin
          state_nxt_s    = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (tx_end) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and launch output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      tx_start_r <= 1'b0;
      tx_data_r  <= 8'h00;
    end else begin
      state_r    <= state_nxt_s;
      tx_start_r <= tx_start_nxt_s;
      tx_data_r  <= tx_data_nxt_s;
    end
  end

  // Pointers, occupancy, status flags and the overflow pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_r <= PTR_ZERO;
        rd_ptr_r <= PTR_ZERO;
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
        if (launch_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
      end
      count_r    <= count_nxt_s;
      full_r     <= (count_nxt_s == CNT_FULL);
      empty_r    <= (count_nxt_s == CNT_ZERO);
      overflow_r <= drop_s;
    end
  end

  // Byte storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  assign full     = full_r;
  assign empty    = empty_r;
  assign count    = count_r;
  assign overflow = overflow_r;
  assign tx_start = tx_start_r;
  assign tx_data  = tx_data_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0;
  logic [7:0]        wr_data = 8'h00;
  logic              flush = 1'b0;
  logic              tx_en = 1'b0;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy = 1'b0;
  logic              tx_end = 1'b0;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: queued bytes plus "a frame is in flight" flag.
  logic [7:0] model_q[$];
  bit         model_waiting = 1'b0;
  logic       exp_start = 1'b0;
  logic [7:0] exp_data  = 8'h00;
  logic       exp_ovf   = 1'b0;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .flush(flush), .tx_en(tx_en), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .tx_end(tx_end)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic f,
                       input logic en, input logic busy, input logic te, input logic rst);
    wr_en = w; wr_data = d; flush = f; tx_en = en; tx_busy = busy; tx_end = te; reset = rst;
  endtask

  // Apply the spec's rules to the inputs sampled at this edge.
  task automatic model_edge();
    bit full_now;
    bit launch;
    if (reset) begin
      model_q.delete();
      model_waiting = 1'b0;
      exp_start = 1'b0;
      exp_data  = 8'h00;
      exp_ovf   = 1'b0;
    end else begin
      full_now = (model_q.size() == DEPTH);
      launch   = !model_waiting && (model_q.size() > 0) && tx_en && !tx_busy && !flush;
      exp_ovf  = wr_en && full_now && !flush;
      if (flush) begin
        model_q.delete();
      end else begin
        if (launch) exp_data = model_q.pop_front();
        if (wr_en && !full_now) model_q.push_back(wr_data);
      end
      if (launch) model_waiting = 1'b1;
      else if (model_waiting && tx_end) model_waiting = 1'b0;
      exp_start = launch;
    end
  endtask

  // One clock: update model at the edge, compare all outputs 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("count",    32'(count),    32'(model_q.size()));
    check_eq("empty",    32'(empty),    32'(model_q.size() == 0));
    check_eq("full",     32'(full),     32'(model_q.size() == DEPTH));
    check_eq("overflow", 32'(overflow), 32'(exp_ovf));
    check_eq("tx_start", 32'(tx_start), 32'(exp_start));
    check_eq("tx_data",  32'(tx_data),  32'(exp_data));
  endtask

  initial begin
    // Reset state
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_data",  32'(tx_data), 32'd0);

    // Single byte A5
    drive(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("a5_count1", 32'(count), 32'd1);
    check_eq("a5_empty0", 32'(empty), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("a5_start", 32'(tx_start), 32'd1);
    check_eq("a5_data",  32'(tx_data), 32'hA5);
    check_eq("a5_count0", 32'(count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("a5_nostart", 32'(tx_start), 32'd0);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();

    // 01,02,03 while busy, then release with tx_end pulses
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      check_eq("busy_nostart", 32'(tx_start), 32'd0);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("seq_start1", 32'(tx_start), 32'd1);
    check_eq("seq_data1",  32'(tx_data), 32'h01);
    for (int i = 2; i <= 3; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick(); tick();
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      check_eq("seq_gap_nostart", 32'(tx_start), 32'd0);
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check_eq("seq_start", 32'(tx_start), 32'd1);
      check_eq("seq_data",  32'(tx_data), 32'(i));
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();

    // Fill with tx_en=0, overflow, then write+launch while full
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    check_eq("fill_full",  32'(full), 32'd1);
    check_eq("fill_count", 32'(count), 32'd16);
    drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("ovf_pulse", 32'(overflow), 32'd1);
    check_eq("ovf_count", 32'(count), 32'd16);
    drive(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("fullpop_ovf",   32'(overflow), 32'd1);
    check_eq("fullpop_count", 32'(count), 32'd15);
    check_eq("fullpop_data",  32'(tx_data), 32'h00);
    for (int i = 1; i < DEPTH; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check_eq("drain_start", 32'(tx_start), 32'd1);
      check_eq("drain_data",  32'(tx_data), 32'(i));
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("drain_noff", 32'(tx_start), 32'd0);
    end

    // Flush during a frame together with a write
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("fl_launch", 32'(tx_data), 32'h10);
    drive(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("fl_count", 32'(count), 32'd0);
    check_eq("fl_ovf",   32'(overflow), 32'd0);
    check_eq("fl_empty", 32'(empty), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("fl_nostart", 32'(tx_start), 32'd0);
    end

    // Reset mid-frame with 5 queued
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("mr_count5", 32'(count), 32'd5);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    check_eq("mr_count", 32'(count), 32'd0);
    check_eq("mr_empty", 32'(empty), 32'd1);
    check_eq("mr_full",  32'(full), 32'd0);
    check_eq("mr_start", 32'(tx_start), 32'd0);
    check_eq("mr_data",  32'(tx_data), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("mr_nostart", 32'(tx_start), 32'd0);
    end

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      drive(1'($urandom_range(0, 99) < 55),
            8'($urandom),
            1'($urandom_range(0, 99) < 3),
            1'($urandom_range(0, 99) < 80),
            1'($urandom_range(0, 99) < 30),
            1'($urandom_range(0, 99) < 20),
            1'($urandom_range(0, 199) == 0));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
